// File: rtl/fetcher_icache_pkg.sv
// Shared definitions for the instruction fetcher and its direct-mapped cache.
package fetcher_icache_pkg;

  localparam int          ICACHE_INDEX_W_DEF = 6;
  localparam logic [31:0] RESET_PC           = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } fetch_state_e;

  // Sequential fetch advances by one 32-bit instruction, wrapping at 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetcher_icache_icache.sv
// Direct-mapped instruction cache array: one 32-bit word per line,
// combinational read by index, single write port used for miss fills.
module fetcher_icache_icache
  import fetcher_icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W_DEF,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               rd_hit,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Next valid vector: a fill marks its line valid.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) valid_d[wr_idx] = 1'b1;
  end

  // Only the valid bits need reset; tag/data are meaningless until valid.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) valid_q <= '0;
    else         valid_q <= valid_d;
  end

  // Tag and data storage written on fill.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/fetcher_icache.sv
// Instruction fetcher: walks the fetch PC through a direct-mapped cache,
// issues hits to the decoder one per cycle, and fetches misses from memory.
module fetcher_icache
  import fetcher_icache_pkg::*;
#(
  parameter int ICACHE_INDEX_W = ICACHE_INDEX_W_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rollback_flag_in,
  input  logic [31:0] rollback_pc_in,
  input  logic        stall_in,
  output logic [31:0] inst_to_decoder,
  output logic [31:0] pc_to_decoder,
  output logic        valid_to_decoder,
  output logic [31:0] pc_to_mem,
  output logic        en_signal_to_mem,
  output logic        drop_flag_to_mem,
  input  logic        ok_flag_from_mem,
  input  logic [31:0] inst_from_mem
);

  localparam int TAG_W = 32 - ICACHE_INDEX_W - 2;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  pc_dec_q, pc_dec_d;
  logic [31:0]  pc_mem_q, pc_mem_d;
  logic         valid_q, valid_d;
  logic         en_q, en_d;

  logic         hit;
  logic [31:0]  hit_data;
  logic         fill_en;

  fetcher_icache_icache #(
    .INDEX_W (ICACHE_INDEX_W),
    .TAG_W   (TAG_W)
  ) u_icache (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rd_idx  (pc_q[ICACHE_INDEX_W+1:2]),
    .rd_tag  (pc_q[31:ICACHE_INDEX_W+2]),
    .rd_hit  (hit),
    .rd_data (hit_data),
    .wr_en   (fill_en),
    .wr_idx  (pc_mem_q[ICACHE_INDEX_W+1:2]),
    .wr_tag  (pc_mem_q[31:ICACHE_INDEX_W+2]),
    .wr_data (inst_from_mem)
  );

  // Abort is forwarded straight through so memory sees it in the same cycle.
  assign drop_flag_to_mem = rollback_flag_in;

  // Next-state logic; rollback wins over everything, rdy_in low freezes all.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    pc_dec_d = pc_dec_q;
    pc_mem_d = pc_mem_q;
    valid_d  = valid_q;
    en_d     = en_q;
    fill_en  = 1'b0;
    if (rdy_in) begin
      if (rollback_flag_in) begin
        pc_d    = rollback_pc_in;
        state_d = ST_IDLE;
        valid_d = 1'b0;
        en_d    = 1'b0;
      end else begin
        valid_d = 1'b0;
        en_d    = 1'b0;
        unique case (state_q)
          ST_IDLE: begin
            if (hit) begin
              if (!stall_in) begin
                valid_d  = 1'b1;
                inst_d   = hit_data;
                pc_dec_d = pc_q;
                pc_d     = pc_next(pc_q);
              end
            end else begin
              en_d     = 1'b1;
              pc_mem_d = pc_q;
              state_d  = ST_WAIT_MEM;
            end
          end
          ST_WAIT_MEM: begin
            // The refilled line then issues through the normal hit path.
            if (ok_flag_from_mem) begin
              fill_en = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Control FSM and registered decoder/memory outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      pc_dec_q <= '0;
      pc_mem_q <= '0;
      valid_q  <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      pc_dec_q <= pc_dec_d;
      pc_mem_q <= pc_mem_d;
      valid_q  <= valid_d;
      en_q     <= en_d;
    end
  end

  assign inst_to_decoder  = inst_q;
  assign pc_to_decoder    = pc_dec_q;
  assign valid_to_decoder = valid_q;
  assign pc_to_mem        = pc_mem_q;
  assign en_signal_to_mem = en_q;

endmodule

// File: doc/fetcher_icache.md
FETCHER_ICACHE -- requirements
Module: fetcher_icache

Interface
REQ-001 Parameter ICACHE_INDEX_W, default 6, log2 of direct-mapped line count (64 lines, one 32-bit instruction each).
REQ-002 clk_in  input  1  system clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 rdy_in  input  1  global ready; low freezes all state and registered outputs.
REQ-005 rollback_flag_in  input  1  misprediction/flush request from commit stage.
REQ-006 rollback_pc_in  input  32  restart PC, valid with rollback_flag_in.
REQ-007 stall_in  input  1  downstream instruction queue full.
REQ-008 inst_to_decoder  output  32  fetched instruction.
REQ-009 pc_to_decoder  output  32  PC of inst_to_decoder.
REQ-010 valid_to_decoder  output  1  one-cycle pulse, instruction/PC valid.
REQ-011 pc_to_mem  output  32  miss address to memory controller.
REQ-012 en_signal_to_mem  output  1  one-cycle fetch request pulse.
REQ-013 drop_flag_to_mem  output  1  abort in-flight fetch.
REQ-014 ok_flag_from_mem  input  1  fetch complete, inst_from_mem valid.
REQ-015 inst_from_mem  input  32  instruction returned by memory controller.

Function
REQ-016 Cache: direct-mapped; index = pc[ICACHE_INDEX_W+1:2], tag = pc[31:ICACHE_INDEX_W+2]; per line valid bit, tag, 32-bit data.
REQ-017 States: IDLE and WAIT_MEM; fetch PC register pc held internally.
REQ-018 IDLE, hit, stall_in low: next edge drives inst/pc_to_decoder from line, valid_to_decoder=1, pc<=pc+4 (mod 2^32); hit latency one cycle, one instruction per cycle sustained.
REQ-019 IDLE, hit, stall_in high: valid_to_decoder=0, pc unchanged.
REQ-020 IDLE, miss: next edge sets en_signal_to_mem=1, pc_to_mem=pc, state WAIT_MEM; en_signal_to_mem SHALL be high exactly one cycle per miss.
REQ-021 WAIT_MEM: en_signal_to_mem=0; on ok_flag_from_mem write inst_from_mem, tag, valid=1 into line at index of pc_to_mem, return to IDLE; instruction then issues via hit path (miss cost = memory latency + 1 cycle).
REQ-022 drop_flag_to_mem SHALL equal rollback_flag_in combinationally, same cycle, regardless of state.
REQ-023 rollback_flag_in high (rdy_in high): next edge pc<=rollback_pc_in, state<=IDLE, valid_to_decoder=0, en_signal_to_mem=0; overrides all other same-cycle events.
REQ-024 ok_flag_from_mem coincident with rollback_flag_in: cache fill SHALL NOT occur.
REQ-025 ok_flag_from_mem in IDLE (stale return): ignored, no fill.
REQ-026 Non-hit outputs: valid_to_decoder=0 every cycle no issue occurs; inst/pc_to_decoder hold last value.
REQ-027 rdy_in low: no state, cache, or output register changes; drop_flag_to_mem still follows rollback_flag_in.

Reset
REQ-028 Reset asserted: pc=0, state=IDLE, all valid bits=0, en_signal_to_mem=0, pc_to_mem=0, valid_to_decoder=0, inst_to_decoder=0, pc_to_decoder=0.
REQ-029 Reset mid-WAIT_MEM: immediate return to reset values; first fetch after release requests address 0.

Structure
REQ-030 Shared defines file holds ICACHE_INDEX_W default, state encodings, reset PC constant.
REQ-031 One sub-module icache (tag/valid/data array, read-by-index, write port) is instantiated; control FSM stays in fetcher_icache.

Verification
REQ-032 Cold start: memory returns 0x00000013 at 0x0 after 5 cycles -> one en pulse with pc_to_mem=0x0, then valid_to_decoder with inst 0x00000013, pc 0x0; next request pc_to_mem=0x4.
REQ-033 Loop re-hit: after 0x0-0xC filled, rollback to 0x0 -> four consecutive valid pulses pc 0x0,0x4,0x8,0xC with no en pulse.
REQ-034 Conflict: fill 0x0, then fetch 0x100 (same index) -> miss, en with pc_to_mem=0x100, line replaced; re-fetch 0x0 misses again.
REQ-035 Rollback in WAIT_MEM for 0x40 with ok_flag_from_mem same cycle, rollback_pc_in=0x80 -> drop_flag_to_mem=1 that cycle, no fill at 0x40, next request pc_to_mem=0x80.
REQ-036 stall_in high for 3 cycles during hits -> no valid pulse, pc held; resumes at held PC when stall_in drops.
REQ-037 rdy_in low 4 cycles mid-miss, then async reset pulse -> no state change while low; all outputs at reset values immediately on reset.
